execute_multicycle: RTL and testbench
=====================================

EXECUTE_MULTICYCLE -- requirements
Module: execute_multicycle

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL provide parameter RADDR, default 5, register-address width.
REQ-003 SHALL provide parameter MUL_EN, default 1; 1 includes the iterative multiplier, 0 treats MULT as ADD.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock), rst_n (input, 1, asynchronous active-low reset).
REQ-005 SHALL provide in_valid (input, 1, ID/EX holds a valid instruction).
REQ-006 SHALL provide mem_stall (input, 1, downstream cannot accept; hold EX/MEM).
REQ-007 SHALL provide stall_out (output, 1, upstream must hold ID/EX).
REQ-008 SHALL provide wb (in, 2), m (in, 3), alu_ctl (in, 4), alu_src (in, 1), reg_dst (in, 1).
REQ-009 SHALL provide npc, rdata1, rdata2, imm (in, WIDTH, imm already sign-extended).
REQ-010 SHALL provide rs, rt, rd (in, RADDR) and fwd_a_sel, fwd_b_sel (in, 2).
REQ-011 SHALL provide mem_alu_result, wb_data (in, WIDTH, forwarding sources).
REQ-012 SHALL provide outputs out_valid (1), wb_ctlout (2), m_ctlout (3), add_result, alu_result, hi_result, rdata2out (WIDTH), zero (1), dest_reg (RADDR), rs_out, rt_out (RADDR, combinational copies of rs, rt).

Function
REQ-013 SHALL compute operand A: fwd_a_sel 00 rdata1, 01 wb_data, 10 mem_alu_result, 11 rdata1.
REQ-014 SHALL compute forwarded B the same way from rdata2; operand B = imm if alu_src=1, else forwarded B; rdata2out captures forwarded B.
REQ-015 SHALL decode alu_ctl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1000 MULT, others result 0; ADD/SUB wrap modulo 2^WIDTH.
REQ-016 SHALL compute add_result = npc + (imm << 2), truncated to WIDTH.
REQ-017 SHALL select dest_reg = rd if reg_dst=1 else rt; zero = (alu_result == 0).
REQ-018 SHALL implement FSM IDLE, MUL, HOLD.
REQ-019 IDLE: accept when in_valid=1 and mem_stall=0; non-MULT registers all EX/MEM outputs next edge with out_valid=1 (latency 1).
REQ-020 IDLE, accepted MULT with MUL_EN=1: latch operands, count=0, go MUL; EX/MEM gets out_valid=0 that edge.
REQ-021 MUL: unsigned shift-add, one bit per cycle, count increments; after WIDTH cycles in MUL, low half to alu_result, high half to hi_result, out_valid=1, next IDLE (total latency WIDTH+1).
REQ-022 MUL: if mem_stall=1 at the completion cycle, go HOLD keeping product; HOLD writes EX/MEM and returns IDLE in the first cycle mem_stall=0.
REQ-023 stall_out = 1 in MUL, in HOLD, or whenever mem_stall=1; else 0.
REQ-024 mem_stall=1: EX/MEM registers, including out_valid, hold value.
REQ-025 IDLE, in_valid=0, mem_stall=0: out_valid=0 next edge, other EX/MEM fields don't-care but SHALL hold.
REQ-026 Forwarding inputs SHALL be sampled only at the accept cycle; MUL ignores later changes on all data inputs.
REQ-027 hi_result SHALL update only on MULT completion.

Reset
REQ-028 rst_n=0 SHALL immediately force FSM IDLE, count 0, and all registered outputs (out_valid, wb_ctlout, m_ctlout, add_result, alu_result, hi_result, rdata2out, dest_reg) to 0; zero reads 1.
REQ-029 Reset during MUL or HOLD SHALL abort the multiply without any EX/MEM write.
REQ-030 After release, first acceptance SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-031 ADD, rdata1=5, rdata2=7, fwd=00, alu_src=0 -> next edge alu_result=12, zero=0, out_valid=1.
REQ-032 SUB, fwd_a_sel=10, mem_alu_result=9, rdata2=9 -> alu_result=0, zero=1; fwd_b_sel=01 wb_data=3 -> rdata2out=3.
REQ-033 MULT, WIDTH=32, A=0xFFFFFFFF, B=2 -> stall_out=1 for 32 cycles, then alu_result=0xFFFFFFFE, hi_result=1, out_valid=1 once.
REQ-034 MULT completion with mem_stall=1 for 3 cycles -> HOLD, outputs unchanged, result appears edge after mem_stall drops.
REQ-035 rst_n=0 at MUL count 10 -> all outputs 0 asynchronously; new ADD 1+1 after release -> 2, hi_result stays 0.
REQ-036 Branch: npc=0x100, imm=0xFFFFFFFF -> add_result=0xFC; SLT A=-1, B=1 -> alu_result=1.

Source files
------------

// File: rtl/execute_multicycle.sv
// EX stage: operand forwarding, single-cycle ALU, branch-target adder and an
// iterative shift-add multiplier that holds the front end while it runs.
module execute_multicycle #(
  parameter int WIDTH  = 32,
  parameter int RADDR  = 5,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mem_stall,
  output logic             stall_out,
  input  logic [1:0]       wb,
  input  logic [2:0]       m,
  input  logic [3:0]       alu_ctl,
  input  logic             alu_src,
  input  logic             reg_dst,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic [WIDTH-1:0] imm,
  input  logic [RADDR-1:0] rs,
  input  logic [RADDR-1:0] rt,
  input  logic [RADDR-1:0] rd,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] mem_alu_result,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  output logic [1:0]       wb_ctlout,
  output logic [2:0]       m_ctlout,
  output logic [WIDTH-1:0] add_result,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] rdata2out,
  output logic             zero,
  output logic [RADDR-1:0] dest_reg,
  output logic [RADDR-1:0] rs_out,
  output logic [RADDR-1:0] rt_out,
  output logic [1:0]       state_dbg
);
  // Handshake: an instruction leaves ID/EX on a rising edge when the FSM is IDLE,
  // in_valid=1 and mem_stall=0; stall_out=1 asks upstream to hold ID/EX, and
  // mem_stall=1 freezes every EX/MEM register including out_valid.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam bit HAS_MUL = (MUL_EN != 0);
  localparam logic [3:0] CTL_AND = 4'b0000, CTL_OR = 4'b0001, CTL_ADD = 4'b0010,
                         CTL_SUB = 4'b0110, CTL_SLT = 4'b0111, CTL_MULT = 4'b1000;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;
  state_t state, next_state;

  logic [WIDTH-1:0] fwd_a, fwd_b, op_b, alu_val, branch_target;
  logic [WIDTH-1:0] mcand, prod_hi, prod_lo, hi_next, lo_next, fin_hi, fin_lo;
  logic [WIDTH:0]   mul_sum;
  logic [CW-1:0]    count;
  logic [1:0]       pend_wb;
  logic [2:0]       pend_m;
  logic [WIDTH-1:0] pend_add, pend_r2;
  logic [RADDR-1:0] pend_dest;
  logic             is_mult, accept, start_mul, load_alu, mul_done, write_mul, clear_valid;

  always_comb begin
    case (fwd_a_sel)
      2'b01:   fwd_a = wb_data;
      2'b10:   fwd_a = mem_alu_result;
      default: fwd_a = rdata1;
    endcase
    case (fwd_b_sel)
      2'b01:   fwd_b = wb_data;
      2'b10:   fwd_b = mem_alu_result;
      default: fwd_b = rdata2;
    endcase
    op_b          = alu_src ? imm : fwd_b;
    branch_target = npc + (imm << 2);
    is_mult       = HAS_MUL && (alu_ctl == CTL_MULT);
  end

  // Without the multiplier, MULT falls through to the adder.
  always_comb begin
    alu_val = '0;
    case (alu_ctl)
      CTL_AND:  alu_val = fwd_a & op_b;
      CTL_OR:   alu_val = fwd_a | op_b;
      CTL_ADD:  alu_val = fwd_a + op_b;
      CTL_SUB:  alu_val = fwd_a - op_b;
      CTL_SLT:  alu_val = {{(WIDTH-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      CTL_MULT: alu_val = HAS_MUL ? '0 : fwd_a + op_b;
      default:  alu_val = '0;
    endcase
  end

  // One multiplier bit per cycle: add multiplicand into the high half, shift right.
  always_comb begin
    mul_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    hi_next = mul_sum[WIDTH:1];
    lo_next = {mul_sum[0], prod_lo[WIDTH-1:1]};
    fin_hi  = (state == MUL) ? hi_next : prod_hi;
    fin_lo  = (state == MUL) ? lo_next : prod_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_mul) next_state = MUL;
      MUL:     if (mul_done) next_state = mem_stall ? HOLD : IDLE;
      HOLD:    if (!mem_stall) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state == IDLE) && in_valid && !mem_stall;
    start_mul   = accept && is_mult;
    load_alu    = accept && !is_mult;
    mul_done    = (state == MUL) && (count == LAST);
    write_mul   = !mem_stall && (mul_done || (state == HOLD));
    clear_valid = start_mul || ((state == IDLE) && !in_valid && !mem_stall);
    stall_out   = (state != IDLE) || mem_stall;
    state_dbg   = state;
  end

  // Multiplier operands and the control fields of the instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0; prod_hi <= '0; prod_lo <= '0; count <= '0;
      pend_wb <= '0; pend_m <= '0; pend_add <= '0; pend_r2 <= '0; pend_dest <= '0;
    end else if (start_mul) begin
      mcand     <= fwd_a;
      prod_hi   <= '0;
      prod_lo   <= op_b;
      count     <= '0;
      pend_wb   <= wb;
      pend_m    <= m;
      pend_add  <= branch_target;
      pend_r2   <= fwd_b;
      pend_dest <= reg_dst ? rd : rt;
    end else if (state == MUL) begin
      prod_hi <= hi_next;
      prod_lo <= lo_next;
      count   <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; wb_ctlout <= '0; m_ctlout <= '0; add_result <= '0;
      alu_result <= '0; hi_result <= '0; rdata2out <= '0; dest_reg <= '0;
    end else if (load_alu) begin
      out_valid  <= 1'b1;
      wb_ctlout  <= wb;
      m_ctlout   <= m;
      add_result <= branch_target;
      alu_result <= alu_val;
      rdata2out  <= fwd_b;
      dest_reg   <= reg_dst ? rd : rt;
    end else if (write_mul) begin
      out_valid  <= 1'b1;
      wb_ctlout  <= pend_wb;
      m_ctlout   <= pend_m;
      add_result <= pend_add;
      alu_result <= fin_lo;
      hi_result  <= fin_hi;
      rdata2out  <= pend_r2;
      dest_reg   <= pend_dest;
    end else if (clear_valid) begin
      out_valid <= 1'b0;
    end
  end

  assign zero   = (alu_result == '0);
  assign rs_out = rs;
  assign rt_out = rt;
endmodule

// File: tb/tb_execute_multicycle.sv
// Self-checking bench for execute_multicycle: directed cases from the requirement
// examples followed by randomized ops, all predicted by a plain-arithmetic model.
module tb_execute_multicycle;
  localparam int W = 32;
  localparam int R = 5;

  logic clk = 1'b0, rst_n, in_valid, mem_stall, stall_out;
  logic [1:0] wb, fwd_a_sel, fwd_b_sel, wb_ctlout, state_dbg;
  logic [2:0] m, m_ctlout;
  logic [3:0] alu_ctl;
  logic alu_src, reg_dst, out_valid, zero;
  logic [W-1:0] npc, rdata1, rdata2, imm, mem_alu_result, wb_data;
  logic [W-1:0] add_result, alu_result, hi_result, rdata2out;
  logic [R-1:0] rs, rt, rd, dest_reg, rs_out, rt_out;

  execute_multicycle #(.WIDTH(W), .RADDR(R), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_stall(mem_stall),
    .stall_out(stall_out), .wb(wb), .m(m), .alu_ctl(alu_ctl), .alu_src(alu_src),
    .reg_dst(reg_dst), .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
    .rs(rs), .rt(rt), .rd(rd), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_alu_result(mem_alu_result), .wb_data(wb_data), .out_valid(out_valid),
    .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
    .alu_result(alu_result), .hi_result(hi_result), .rdata2out(rdata2out),
    .zero(zero), .dest_reg(dest_reg), .rs_out(rs_out), .rt_out(rt_out),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // expected EX/MEM state and the prediction for the instruction in flight
  int checks = 0, failures = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_valid;
  logic [1:0]   exp_wb, pend_wb;
  logic [2:0]   exp_m, pend_m;
  logic [W-1:0] exp_add, exp_alu, exp_hi, exp_r2, pend_add, pend_hi, pend_r2;
  logic [R-1:0] exp_dest, pend_dest;
  logic [3:0]   ctl_list [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h3, 4'hF};

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] rf,
                                        input logic [W-1:0] wbd, input logic [W-1:0] mem);
    if (sel == 2'b01) return wbd;
    if (sel == 2'b10) return mem;
    return rf;
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [3:0] ctl, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (ctl)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic predict();
    logic [W-1:0] a, fb, b;
    logic [63:0] p;
    a  = pick(fwd_a_sel, rdata1, wb_data, mem_alu_result);
    fb = pick(fwd_b_sel, rdata2, wb_data, mem_alu_result);
    b  = alu_src ? imm : fb;
    pend_wb   = wb;
    pend_m    = m;
    pend_add  = npc + imm * 32'd4;
    pend_r2   = fb;
    pend_dest = reg_dst ? rd : rt;
    if (alu_ctl == 4'b1000) begin
      p = 64'(a) * 64'(b);
      exp_q.push_back(p[W-1:0]);
      pend_hi = p[63:32];
    end else begin
      exp_q.push_back(ref_alu(alu_ctl, a, b));
      pend_hi = exp_hi;
    end
  endtask

  task automatic commit();
    exp_valid = 1'b1;
    exp_wb    = pend_wb;
    exp_m     = pend_m;
    exp_add   = pend_add;
    exp_alu   = exp_q.pop_front();
    exp_hi    = pend_hi;
    exp_r2    = pend_r2;
    exp_dest  = pend_dest;
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_wb = '0; exp_m = '0; exp_add = '0; exp_alu = '0;
    exp_hi = '0; exp_r2 = '0; exp_dest = '0;
    exp_q.delete();
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(exp_valid));
    check({tag, "_wb"},    64'(wb_ctlout), 64'(exp_wb));
    check({tag, "_m"},     64'(m_ctlout),  64'(exp_m));
    check({tag, "_add"},   64'(add_result), 64'(exp_add));
    check({tag, "_alu"},   64'(alu_result), 64'(exp_alu));
    check({tag, "_hi"},    64'(hi_result),  64'(exp_hi));
    check({tag, "_r2"},    64'(rdata2out),  64'(exp_r2));
    check({tag, "_dest"},  64'(dest_reg),   64'(exp_dest));
    check({tag, "_zero"},  64'(zero),       64'(exp_alu == '0));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; mem_stall = 0; wb = 0; m = 0; alu_ctl = 0; alu_src = 0; reg_dst = 0;
    npc = 0; rdata1 = 0; rdata2 = 0; imm = 0; rs = 0; rt = 0; rd = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; mem_alu_result = 0; wb_data = 0;
  endtask

  task automatic rand_inputs();
    wb = 2'($urandom_range(0, 3)); m = 3'($urandom_range(0, 7));
    alu_ctl = ctl_list[$urandom_range(0, 7)];
    alu_src = 1'($urandom_range(0, 1)); reg_dst = 1'($urandom_range(0, 1));
    npc = $urandom; rdata1 = $urandom; rdata2 = $urandom; imm = $urandom;
    rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
    fwd_a_sel = 2'($urandom_range(0, 3)); fwd_b_sel = 2'($urandom_range(0, 3));
    mem_alu_result = $urandom; wb_data = $urandom;
  endtask

  // Accept a MULT already set up on the inputs, scramble inputs while it runs,
  // and count cycles with stall_out high up to the cycle before completion.
  task automatic run_mul_body(input string tag, output int stall_cycles);
    predict();
    step();
    exp_valid = 1'b0;
    check_all({tag, "_acc"});
    stall_cycles = stall_out ? 1 : 0;
    rand_inputs();
    in_valid = 1'($urandom_range(0, 1));
    mem_stall = 0;
    for (int i = 0; i < W - 1; i++) begin
      step();
      if (stall_out) stall_cycles++;
      check({tag, "_busy_valid"}, 64'(out_valid), 64'(0));
    end
  endtask

  initial begin
    int sc;
    clear_inputs();
    model_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    check("rst_stall", 64'(stall_out), 64'(0));
    rst_n = 1;

    // ADD 5+7 on the first edge after reset release
    alu_ctl = 4'b0010; rdata1 = 5; rdata2 = 7; rs = 3; rt = 4; rd = 9; reg_dst = 1;
    wb = 2'b10; m = 3'b101; in_valid = 1;
    #1;
    check("rs_out", 64'(rs_out), 64'(3));
    check("rt_out", 64'(rt_out), 64'(4));
    predict(); step(); commit();
    check_all("add");
    check("add_const", 64'(alu_result), 64'(12));
    check("add_zero_const", 64'(zero), 64'(0));

    // SUB with A forwarded from MEM, then B forwarded from WB
    clear_inputs();
    alu_ctl = 4'b0110; fwd_a_sel = 2'b10; mem_alu_result = 9; rdata1 = 77; rdata2 = 9;
    in_valid = 1;
    predict(); step(); commit();
    check_all("sub");
    check("sub_zero_const", 64'(zero), 64'(1));
    fwd_b_sel = 2'b01; wb_data = 3;
    predict(); step(); commit();
    check_all("sub_fwdb");
    check("fwdb_r2_const", 64'(rdata2out), 64'(3));

    // branch target with negative immediate, SLT -1 < 1
    clear_inputs();
    alu_ctl = 4'b0111; npc = 32'h100; imm = 32'hFFFF_FFFF; rdata1 = 32'hFFFF_FFFF;
    rdata2 = 1; in_valid = 1;
    predict(); step(); commit();
    check_all("slt");
    check("branch_const", 64'(add_result), 64'(32'hFC));
    check("slt_const", 64'(alu_result), 64'(1));

    // mem_stall holds a valid EX/MEM, then idle clears out_valid only
    in_valid = 0; mem_stall = 1;
    #1;
    check("mstall_stall_out", 64'(stall_out), 64'(1));
    step();
    check_all("mstall_hold");
    mem_stall = 0;
    step();
    exp_valid = 0;
    check_all("idle");
    rand_inputs(); alu_ctl = 4'b0001; in_valid = 1; mem_stall = 1;
    step();
    check_all("mstall_block");
    mem_stall = 0;
    predict(); step(); commit();
    check_all("after_mstall");

    // MULT 0xFFFFFFFF * 2
    clear_inputs();
    alu_ctl = 4'b1000; rdata1 = 32'hFFFF_FFFF; rdata2 = 2; in_valid = 1;
    run_mul_body("mul", sc);
    check("mul_stall_cycles", 64'(sc), 64'(W));
    step(); commit();
    check_all("mul_done");
    check("mul_lo_const", 64'(alu_result), 64'(32'hFFFF_FFFE));
    check("mul_hi_const", 64'(hi_result), 64'(1));
    check("mul_done_stall", 64'(stall_out), 64'(0));
    in_valid = 0;
    step();
    exp_valid = 0;
    check("mul_once", 64'(out_valid), 64'(0));

    // MULT completing under a 3-cycle mem_stall
    clear_inputs();
    alu_ctl = 4'b1000; fwd_a_sel = 2'b01; wb_data = 32'h1234_5678; alu_src = 1;
    imm = 32'h9ABC_DEF0; in_valid = 1;
    run_mul_body("hmul", sc);
    in_valid = 0; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("hold");
      check("hold_stall", 64'(stall_out), 64'(1));
    end
    mem_stall = 0;
    step(); commit();
    check_all("hold_done");

    // reset at multiply count 10 aborts it
    clear_inputs();
    alu_ctl = 4'b1000; rdata1 = 3; rdata2 = 5; in_valid = 1;
    predict();
    step();
    in_valid = 0;
    repeat (10) step();
    rst_n = 0;
    #1;
    model_reset();
    check_all("abort");
    check("abort_stall", 64'(stall_out), 64'(0));
    rst_n = 1;
    alu_ctl = 4'b0010; rdata1 = 1; rdata2 = 1; in_valid = 1;
    predict(); step(); commit();
    check_all("post_abort");
    check("post_abort_const", 64'(alu_result), 64'(2));
    check("post_abort_hi", 64'(hi_result), 64'(0));

    // randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      rand_inputs();
      in_valid = 1; mem_stall = 0;
      if (alu_ctl == 4'b1000) begin
        run_mul_body("rmul", sc);
        check("rmul_stall_cycles", 64'(sc), 64'(W));
        in_valid = 0;
        step(); commit();
        check_all("rmul_done");
      end else begin
        predict(); step(); commit();
        check_all("rop");
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        step();
        exp_valid = 0;
        check_all("ridle");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
